// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states, ALU op codes,
// opcode/funct values and instruction classes.
package multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StTrap   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    AluAdd  = 3'd0,
    AluSub  = 3'd1,
    AluAnd  = 3'd2,
    AluOr   = 3'd3,
    AluSlt  = 3'd4,
    AluSltu = 3'd5
  } alu_op_e;

  typedef enum logic [3:0] {
    ClsNop,
    ClsRAlu,
    ClsIAlu,
    ClsLw,
    ClsSw,
    ClsBeq,
    ClsBne,
    ClsJ,
    ClsJal,
    ClsJr,
    ClsIllegal
  } ins_class_e;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpAddiu = 6'h09;
  localparam logic [5:0] OpSlti  = 6'h0a;
  localparam logic [5:0] OpSltiu = 6'h0b;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2b;

  localparam logic [5:0] FnJr   = 6'h08;
  localparam logic [5:0] FnAdd  = 6'h20;
  localparam logic [5:0] FnAddu = 6'h21;
  localparam logic [5:0] FnSub  = 6'h22;
  localparam logic [5:0] FnSubu = 6'h23;
  localparam logic [5:0] FnAnd  = 6'h24;
  localparam logic [5:0] FnOr   = 6'h25;
  localparam logic [5:0] FnSlt  = 6'h2a;
  localparam logic [5:0] FnSltu = 6'h2b;

  localparam logic [1:0] PcSrcSeq    = 2'd0;
  localparam logic [1:0] PcSrcBranch = 2'd1;
  localparam logic [1:0] PcSrcJump   = 2'd2;
  localparam logic [1:0] PcSrcReg    = 2'd3;

  localparam logic [1:0] WbSelAlu = 2'd0;
  localparam logic [1:0] WbSelMem = 2'd1;
  localparam logic [1:0] WbSelPc4 = 2'd2;

  // Control-transfer classes finish (and retire) in EXEC.
  function automatic logic retires_in_exec(ins_class_e c);
    return (c == ClsBeq) || (c == ClsBne) || (c == ClsJ) || (c == ClsJal) || (c == ClsJr);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational instruction decoder: classifies the IR contents and derives the
// ALU operation, operand-B select and legality.
module mc_ctrl_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [31:0] ins_i,
  output ins_class_e  cls_o,
  output alu_op_e     alu_op_o,
  output logic        alu_src_b_o,
  output logic        legal_o
);

  logic [5:0] opcode;
  logic [5:0] funct;

  assign opcode = ins_i[31:26];
  assign funct  = ins_i[5:0];

  always_comb begin
    cls_o       = ClsIllegal;
    alu_op_o    = AluAdd;
    alu_src_b_o = 1'b0;
    if (ins_i == '0) begin
      cls_o = ClsNop;
    end else begin
      case (opcode)
        OpRtype: begin
          cls_o = ClsRAlu;
          case (funct)
            FnAdd, FnAddu: alu_op_o = AluAdd;
            FnSub, FnSubu: alu_op_o = AluSub;
            FnAnd:         alu_op_o = AluAnd;
            FnOr:          alu_op_o = AluOr;
            FnSlt:         alu_op_o = AluSlt;
            FnSltu:        alu_op_o = AluSltu;
            FnJr:          cls_o    = ClsJr;
            default:       cls_o    = ClsIllegal;
          endcase
        end
        OpAddi, OpAddiu: begin
          cls_o       = ClsIAlu;
          alu_src_b_o = 1'b1;
        end
        OpSlti: begin
          cls_o       = ClsIAlu;
          alu_op_o    = AluSlt;
          alu_src_b_o = 1'b1;
        end
        OpSltiu: begin
          cls_o       = ClsIAlu;
          alu_op_o    = AluSltu;
          alu_src_b_o = 1'b1;
        end
        OpLw: begin
          cls_o       = ClsLw;
          alu_src_b_o = 1'b1;
        end
        OpSw: begin
          cls_o       = ClsSw;
          alu_src_b_o = 1'b1;
        end
        OpBeq: begin
          cls_o    = ClsBeq;
          alu_op_o = AluSub;
        end
        OpBne: begin
          cls_o    = ClsBne;
          alu_op_o = AluSub;
        end
        OpJ:     cls_o = ClsJ;
        OpJal:   cls_o = ClsJal;
        default: cls_o = ClsIllegal;
      endcase
    end
    legal_o = (cls_o != ClsIllegal);
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS core: sequences fetch/decode/exec/mem/wb,
// drives all datapath write strobes, counts retired instructions and traps on
// illegal opcodes. Define MC_CTRL_MEM_WAIT_EN to stall MEM until MemRdy.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Run,
  input  logic [31:0]      Ins,
  input  logic             Zero,
  input  logic             MemRdy,
  output logic             PcWe,
  output logic [1:0]       PcSrc,
  output logic             IrWe,
  output logic             RegWe,
  output logic [1:0]       WbSel,
  output logic             MemRe,
  output logic             MemWe,
  output logic             AluSrcB,
  output logic [2:0]       AluOp,
  output logic [2:0]       State,
  output logic             Illegal,
  output logic [CNT_W-1:0] InsCount
);

  state_e           state_q, state_d;
  logic             retire;
  logic             mem_done;
  logic [CNT_W-1:0] cnt_q;
  ins_class_e       cls;
  alu_op_e          alu_op;
  logic             alu_src_b;
  logic             legal;

  mc_ctrl_decode u_decode (
    .ins_i       (Ins),
    .cls_o       (cls),
    .alu_op_o    (alu_op),
    .alu_src_b_o (alu_src_b),
    .legal_o     (legal)
  );

`ifdef MC_CTRL_MEM_WAIT_EN
  assign mem_done = MemRdy;
`else
  logic unused_mem_rdy;
  assign unused_mem_rdy = MemRdy;
  assign mem_done       = 1'b1;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StFetch;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (retire) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      StFetch: begin
        if (Run) begin
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (cls == ClsNop) begin
          state_d = StFetch;
          retire  = 1'b1;
        end else if (!legal) begin
          state_d = StTrap;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        if (retires_in_exec(cls)) begin
          state_d = StFetch;
          retire  = 1'b1;
        end else if (cls == ClsLw || cls == ClsSw) begin
          state_d = StMem;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        if (mem_done) begin
          if (cls == ClsSw) begin
            state_d = StFetch;
            retire  = 1'b1;
          end else begin
            state_d = StWb;
          end
        end
      end
      StWb: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StTrap:  state_d = StTrap;
      default: state_d = StFetch;
    endcase
  end

  always_comb begin
    PcWe    = 1'b0;
    PcSrc   = PcSrcSeq;
    IrWe    = 1'b0;
    RegWe   = 1'b0;
    WbSel   = WbSelAlu;
    MemRe   = 1'b0;
    MemWe   = 1'b0;
    AluSrcB = 1'b0;
    AluOp   = AluAdd;
    // ALU controls stay valid through MEM/WB so the address/result stays stable.
    if (state_q == StExec || state_q == StMem || state_q == StWb) begin
      AluSrcB = alu_src_b;
      AluOp   = alu_op;
    end
    case (state_q)
      StFetch: begin
        if (Run) begin
          MemRe = 1'b1;
          IrWe  = 1'b1;
          PcWe  = 1'b1;
        end
      end
      StExec: begin
        case (cls)
          ClsBeq: begin
            PcWe  = Zero;
            PcSrc = PcSrcBranch;
          end
          ClsBne: begin
            PcWe  = !Zero;
            PcSrc = PcSrcBranch;
          end
          ClsJ: begin
            PcWe  = 1'b1;
            PcSrc = PcSrcJump;
          end
          ClsJal: begin
            PcWe  = 1'b1;
            PcSrc = PcSrcJump;
            RegWe = 1'b1;
            WbSel = WbSelPc4;
          end
          ClsJr: begin
            PcWe  = 1'b1;
            PcSrc = PcSrcReg;
          end
          default: ;
        endcase
      end
      StMem: begin
        MemRe = (cls == ClsLw);
        MemWe = (cls == ClsSw);
      end
      StWb: begin
        RegWe = 1'b1;
        WbSel = (cls == ClsLw) ? WbSelMem : WbSelAlu;
      end
      default: ;
    endcase
    if (RST) begin
      PcWe  = 1'b0;
      IrWe  = 1'b0;
      RegWe = 1'b0;
      MemRe = 1'b0;
      MemWe = 1'b0;
    end
  end

  assign State    = state_q;
  assign Illegal  = (state_q == StTrap);
  assign InsCount = cnt_q;

endmodule
